imm_gen: RTL and testbench
==========================

IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 Parameter XLEN, default REG_LEN (32); legal values 32 or 64; width of generated immediate.
REQ-002 Parameter DEPTH, default 2; output buffer entries; power of two, >= 2.
REQ-003 Parameter TAG_W, default 5; width of sideband tag carried with each instruction.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  buffer can accept; registered, independent of out_ready.
REQ-008 in_instr  input  32  raw RV32/RV64 instruction word.
REQ-009 in_tag  input  TAG_W  opaque tag (e.g. rd or ROB index), returned unchanged.
REQ-010 flush  input  1  synchronous discard of all buffered entries.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  consumer accepts head.
REQ-013 out_imm  output  XLEN  sign-extended immediate.
REQ-014 out_type  output  imm_type  decoded immediate format.
REQ-015 out_tag  output  TAG_W  tag of head entry.
REQ-016 out_illegal  output  1  opcode has no known format.
REQ-017 illegal_cnt  output  16  saturating count of accepted illegal opcodes.

Function
REQ-018 Push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 Opcode in_instr[6:0] selects: 0110111/0010111 -> IMM_U; 1101111 -> IMM_J; 1100011 -> IMM_B; 0100011 -> IMM_S; 0000011/0010011/1100111/1110011 -> IMM_I; 0011011 -> IMM_I only when XLEN=64; else IMM_DEFAULT with illegal=1.
REQ-020 Fields: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0}; J {31,19:12,20,30:21,0}; all sign-extended from instr[31] to XLEN; IMM_DEFAULT -> all zeros.
REQ-021 Latency exactly 1 cycle: entry pushed at edge N is visible on outputs after edge N, out_valid high in cycle N+1 if buffer was empty.
REQ-022 Strict FIFO order; read/write pointers wrap modulo DEPTH.
REQ-023 in_ready = (count < DEPTH); full buffer deasserts in_ready even if out_ready high that cycle.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both complete.
REQ-025 Empty: out_valid=0; out_imm=0, out_type=IMM_DEFAULT, out_tag=0, out_illegal=0.
REQ-026 While out_valid && !out_ready, all out_* stable.
REQ-027 flush: next cycle count=0, out_valid=0, in_ready=1; a push in the flush cycle is dropped and not counted; illegal_cnt unaffected.
REQ-028 illegal_cnt increments by 1 per accepted illegal instruction, saturates at 0xFFFF.

Reset
REQ-029 rst_n low asynchronously clears count, pointers, illegal_cnt; out_valid=0, in_ready=1, out_* as REQ-025.
REQ-030 Reset mid-operation discards all entries; first push after release behaves as from empty.

Structure
REQ-031 Enum imm_type (IMM_J, IMM_U, IMM_B, IMM_S, IMM_I, IMM_DEFAULT) and opcode constants SHALL live in shared package immPkg; XLEN default SHALL come from rysyPkg::REG_LEN.
REQ-032 Storage SHALL be one sub-module imm_fifo (parametrised width/DEPTH, push/pop/flush, count); decode logic stays in imm_gen.

Verification
REQ-033 XLEN=32, push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, IMM_I, illegal=0.
REQ-034 XLEN=64, push 0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, IMM_U; push 0xFE000EE3 (beq -4) -> 0xFFFFFFFFFFFFFFFC, IMM_B.
REQ-035 DEPTH=2, out_ready=0, push tags 1,2,3 back-to-back -> in_ready low after tag 2, tag 3 held; raise out_ready -> tags out 1,2,3, no loss or duplication.
REQ-036 Push 0x0000007F -> out_illegal=1, out_imm=0, IMM_DEFAULT, illegal_cnt=1; force 0xFFFF then another illegal -> stays 0xFFFF.
REQ-037 Buffer full, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, count=0, pushed item never appears.
REQ-038 rst_n low mid-stream with 1 entry held -> immediately out_valid=0, illegal_cnt=0; after release first push appears 1 cycle later.

Source files
------------

// File: rtl/immPkg.sv
// Immediate formats, RISC-V base opcodes and the opcode-to-format decode
// shared by the immediate generator and its users.
package immPkg;
  typedef enum logic [2:0] {
    IMM_J,
    IMM_U,
    IMM_B,
    IMM_S,
    IMM_I,
    IMM_DEFAULT
  } imm_type;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  // OP-IMM-32 (addiw and friends) only exists on RV64.
  function automatic imm_type imm_format(input logic [6:0] opcode, input logic rv64);
    imm_type fmt;
    fmt = IMM_DEFAULT;
    case (opcode)
      OP_LUI, OP_AUIPC:                    fmt = IMM_U;
      OP_JAL:                              fmt = IMM_J;
      OP_BRANCH:                           fmt = IMM_B;
      OP_STORE:                            fmt = IMM_S;
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = IMM_I;
      OP_IMM_32:                           fmt = rv64 ? IMM_I : IMM_DEFAULT;
      default:                             fmt = IMM_DEFAULT;
    endcase
    return fmt;
  endfunction
endpackage

// File: rtl/rysyPkg.sv
// Core-wide architectural constants shared across the rysy codebase.
package rysyPkg;
  localparam int unsigned REG_LEN = 32;
endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready bundle between an instruction source, the immediate generator
// and the consumer of decoded immediates.
interface imm_gen_if import rysyPkg::*, immPkg::*; #(
  parameter int unsigned XLEN  = REG_LEN,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_type          out_type;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [15:0]      illegal_cnt;

  modport master (
    output in_valid, in_instr, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_tag, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_tag, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_fifo.sv
// Small circular buffer holding decoded immediates; pointers wrap naturally
// because DEPTH is a power of two.
module imm_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && (count != FULL_CNT);
  assign do_pop  = pop  && !flush && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Raw head; the owner masks it when the buffer is empty.
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/imm_gen.sv
// RISC-V immediate generator: decodes the immediate of each accepted
// instruction and queues it, with its tag, for an in-order consumer.
module imm_gen import rysyPkg::*, immPkg::*; #(
  parameter int unsigned XLEN  = REG_LEN,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  imm_gen_if.slave  bus
);
  localparam int unsigned     CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_CNT = DEPTH[CW-1:0];
  localparam logic            RV64     = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type          typ;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t          new_entry;
  entry_t          head_raw;
  entry_t          head;
  imm_type         fmt;
  logic [31:0]     imm32;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            out_valid;
  logic            in_ready;
  logic [15:0]     ill_cnt;

  // Immediates are assembled at 32 bits, then sign-extended to XLEN.
  always_comb begin
    fmt   = imm_format(bus.in_instr[6:0], RV64);
    imm32 = '0;
    case (fmt)
      IMM_I: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      IMM_S: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      IMM_B: imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                      bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      IMM_U: imm32 = {bus.in_instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                      bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    new_entry.imm     = XLEN'($signed(imm32));
    new_entry.typ     = fmt;
    new_entry.tag     = bus.in_tag;
    new_entry.illegal = (fmt == IMM_DEFAULT);
  end

  // A push coinciding with flush is dropped entirely, including its count.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready;

  imm_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (new_entry),
    .rdata (head_raw),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (push && new_entry.illegal && (ill_cnt != '1)) begin
      ill_cnt <= ill_cnt + 16'd1;
    end
  end

  always_comb begin
    head = head_raw;
    if (!out_valid) begin
      head     = '0;
      head.typ = IMM_DEFAULT;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_imm     = head.imm;
  assign bus.out_type    = head.typ;
  assign bus.out_tag     = head.tag;
  assign bus.out_illegal = head.illegal;
  assign bus.illegal_cnt = ill_cnt;
endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: an RV32 and an RV64 instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_imm_gen;
  import immPkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 5;

  typedef struct {
    logic [31:0]      ins;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_ready;

  int   n_vec  = 0;
  int   n_fail = 0;
  ent_t mq[$];
  int   mc32, mc64;
  bit   m_rdy;

  imm_gen_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_instr  = in_instr;
  assign if32.in_tag    = in_tag;
  assign if32.flush     = flush;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_instr  = in_instr;
  assign if64.in_tag    = in_tag;
  assign if64.flush     = flush;
  assign if64.out_ready = out_ready;

  imm_gen #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave));
  imm_gen #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(if64.slave));

  always #5 clk = ~clk;

  function automatic imm_type m_fmt(input logic [31:0] ins, input bit rv64);
    case (ins[6:0])
      7'h37, 7'h17:               return IMM_U;
      7'h6F:                      return IMM_J;
      7'h63:                      return IMM_B;
      7'h23:                      return IMM_S;
      7'h03, 7'h13, 7'h67, 7'h73: return IMM_I;
      7'h1B:                      return rv64 ? IMM_I : IMM_DEFAULT;
      default:                    return IMM_DEFAULT;
    endcase
  endfunction

  // Field values weighted by bit position, then two's-complement wrapped.
  function automatic logic [63:0] m_imm(input logic [31:0] ins, input bit rv64);
    longint v;
    case (m_fmt(ins, rv64))
      IMM_I: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      IMM_S: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      IMM_B: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      IMM_U: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      IMM_J: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return rv64 ? 64'(v) : {32'h0, v[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of accepted instructions plus per-width counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mc32 = 0;
      mc64 = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_rdy = (mq.size() < DEPTH);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && m_rdy) begin
        mq.push_back('{ins: in_instr, tag: in_tag});
        if (m_fmt(in_instr, 1'b0) == IMM_DEFAULT && mc32 < 65535) mc32++;
        if (m_fmt(in_instr, 1'b1) == IMM_DEFAULT && mc64 < 65535) mc64++;
      end
    end
  end

  task automatic cmp(input string nm, input bit rv64, input logic ir, input logic ov,
                     input logic [63:0] imm, input logic [2:0] typ,
                     input logic [TAG_W-1:0] tag, input logic il, input logic [15:0] cnt);
    logic [63:0]      e_imm;
    logic [2:0]       e_typ;
    logic [TAG_W-1:0] e_tag;
    logic             e_il;
    if (mq.size() > 0) begin
      e_imm = m_imm(mq[0].ins, rv64);
      e_typ = m_fmt(mq[0].ins, rv64);
      e_tag = mq[0].tag;
      e_il  = (m_fmt(mq[0].ins, rv64) == IMM_DEFAULT);
    end else begin
      e_imm = '0;
      e_typ = IMM_DEFAULT;
      e_tag = '0;
      e_il  = 1'b0;
    end
    chk({nm, "_in_ready"},    64'(ir),  64'(mq.size() < DEPTH));
    chk({nm, "_out_valid"},   64'(ov),  64'(mq.size() > 0));
    chk({nm, "_out_imm"},     imm,      e_imm);
    chk({nm, "_out_type"},    64'(typ), 64'(e_typ));
    chk({nm, "_out_tag"},     64'(tag), 64'(e_tag));
    chk({nm, "_out_illegal"}, 64'(il),  64'(e_il));
    chk({nm, "_illegal_cnt"}, 64'(cnt), 64'(rv64 ? mc64 : mc32));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp("d32", 1'b0, if32.in_ready, if32.out_valid, 64'(if32.out_imm), if32.out_type,
          if32.out_tag, if32.out_illegal, if32.illegal_cnt);
      cmp("d64", 1'b1, if64.in_ready, if64.out_valid, if64.out_imm, if64.out_type,
          if64.out_tag, if64.out_illegal, if64.illegal_cnt);
    end
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_32_out_valid"}, 64'(if32.out_valid),   64'd0);
    chk({nm, "_32_in_ready"},  64'(if32.in_ready),    64'd1);
    chk({nm, "_32_out_imm"},   64'(if32.out_imm),     64'd0);
    chk({nm, "_32_out_type"},  64'(if32.out_type),    64'(IMM_DEFAULT));
    chk({nm, "_32_out_tag"},   64'(if32.out_tag),     64'd0);
    chk({nm, "_32_illegal"},   64'(if32.out_illegal), 64'd0);
    chk({nm, "_32_cnt"},       64'(if32.illegal_cnt), 64'd0);
    chk({nm, "_64_out_valid"}, 64'(if64.out_valid),   64'd0);
    chk({nm, "_64_in_ready"},  64'(if64.in_ready),    64'd1);
    chk({nm, "_64_out_imm"},   if64.out_imm,          64'd0);
    chk({nm, "_64_cnt"},       64'(if64.illegal_cnt), 64'd0);
  endtask

  logic [TAG_W-1:0] got[$];
  logic [6:0]       ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03,
                                 7'h13, 7'h67, 7'h73, 7'h1B, 7'h7F, 7'h33};
  bit               sent3;
  int unsigned      k;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("addi_valid",   64'(if32.out_valid),   64'd1);
    chk("addi_imm32",   64'(if32.out_imm),     64'hFFFF_FFFF);
    chk("addi_type",    64'(if32.out_type),    64'(IMM_I));
    chk("addi_illegal", 64'(if32.out_illegal), 64'd0);
    chk("addi_imm64",   if64.out_imm,          64'hFFFF_FFFF_FFFF_FFFF);

    // lui 0x80000 then beq -4, back to back
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h800000B7;
    @(negedge clk);
    in_instr = 32'hFE000EE3;
    chk("lui_imm64",  if64.out_imm,       64'hFFFF_FFFF_8000_0000);
    chk("lui_type",   64'(if64.out_type), 64'(IMM_U));
    @(negedge clk);
    in_valid = 1'b0;
    chk("beq_imm64",  if64.out_imm,       64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_type",   64'(if64.out_type), 64'(IMM_B));
    chk("beq_imm32",  64'(if32.out_imm),  64'hFFFF_FFFC);
    @(negedge clk);

    // Back-pressure: third tag must wait, then all three drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 5'd1;
    @(negedge clk);
    in_tag = 5'd2;
    @(negedge clk);
    chk("full_in_ready", 64'(if32.in_ready), 64'd0);
    in_tag = 5'd3;
    @(negedge clk);
    chk("held_in_ready", 64'(if32.in_ready), 64'd0);
    chk("held_head_tag", 64'(if32.out_tag),  64'd1);
    out_ready = 1'b1;
    sent3 = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (if32.out_valid) got.push_back(if32.out_tag);
      if (in_valid && if32.in_ready) sent3 = 1'b1;
      @(negedge clk);
      if (sent3) in_valid = 1'b0;
    end
    chk("order_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("order_%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(i + 1));

    // Flush of a full buffer with an offered instruction
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 5'd4;
    @(negedge clk);
    in_tag = 5'd5;
    @(negedge clk);
    in_instr = 32'h0000007F; in_tag = 5'd9; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", 64'(if32.out_valid), 64'd0);
    chk("flush_full_ready", 64'(if32.in_ready),  64'd1);

    // Flush with room: the offered illegal push is dropped and not counted
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 5'd6;
    @(negedge clk);
    in_instr = 32'h0000007F; in_tag = 5'd9; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_push_valid", 64'(if32.out_valid),   64'd0);
    chk("flush_push_cnt",   64'(if32.illegal_cnt), 64'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      k = $urandom_range(0, 12);
      in_instr = $urandom();
      if (k < 12) in_instr[6:0] = ops[k];
      in_tag = TAG_W'($urandom());
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end

    // Asynchronous reset with one entry held
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(if32.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00A00093; in_tag = 5'd11; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_reset_valid", 64'(if32.out_valid), 64'd1);
    chk("post_reset_tag",   64'(if32.out_tag),   64'd11);
    @(negedge clk);

    // Illegal opcode and counter saturation
    in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = '0;
    @(negedge clk);
    chk("ill_flag",  64'(if32.out_illegal), 64'd1);
    chk("ill_imm",   64'(if32.out_imm),     64'd0);
    chk("ill_type",  64'(if32.out_type),    64'(IMM_DEFAULT));
    chk("ill_cnt32", 64'(if32.illegal_cnt), 64'd1);
    chk("ill_cnt64", 64'(if64.illegal_cnt), 64'd1);
    for (int i = 0; i < 65533; i++) @(negedge clk);
    chk("sat_fffe", 64'(if32.illegal_cnt), 64'hFFFE);
    @(negedge clk);
    chk("sat_ffff", 64'(if32.illegal_cnt), 64'hFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sat_hold32", 64'(if32.illegal_cnt), 64'hFFFF);
    chk("sat_hold64", 64'(if64.illegal_cnt), 64'hFFFF);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
